// File: rtl/mtr_duty_ctrl.sv
// Motor duty/direction controller: two-stage |speed| + stiction offset pipeline,
// PWM-synchronous direction FSM with dead time, and period-based over-current shutdown.
module mtr_duty_ctrl #(
  parameter logic [10:0] MIN_DUTY  = 11'd160,
  parameter int          DEAD_CYC  = 2,
  parameter int          OVR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] spd,
  input  logic        PWM_synch,
  input  logic        OVR_I_blank_n,
  input  logic        OVR_I,
  input  logic        clr_fault,
  output logic [10:0] duty,
  output logic        fwd,
  output logic        rev,
  output logic        OVR_I_shtdwn,
  output logic [1:0]  state_dbg
);

  localparam int DW = (DEAD_CYC < 2) ? 1 : $clog2(DEAD_CYC + 1);
  localparam int OW = (OVR_LIMIT < 2) ? 1 : $clog2(OVR_LIMIT + 1);
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_CYC);
  localparam logic [OW-1:0] OVR_MAX   = OW'(OVR_LIMIT);

  typedef enum logic [1:0] {RUN = 2'd0, DEAD = 2'd1, FAULT = 2'd2} state_t;

  state_t          state;
  logic            dir;
  logic [DW-1:0]   dead_cnt;
  logic [OW-1:0]   ovr_cnt;
  logic            hot;
  logic [11:0]     mag;
  logic            sgn1;
  logic [10:0]     duty_calc;
  logic            sgn2;
  logic            ovr_s1;
  logic            ovr_s2;
  logic [12:0]     sum13;
  logic [10:0]     calc_next;
  logic            period_hot;

  assign state_dbg = state;

  // 13-bit sum so mag=2048 plus the offset cannot wrap before saturation.
  assign sum13 = {1'b0, mag} + {2'b00, MIN_DUTY};

  always_comb begin
    calc_next = '0;
    if (mag != '0) calc_next = (sum13 > 13'd2047) ? 11'd2047 : sum13[10:0];
  end

  // The synch cycle itself is the last cycle of the period, so it counts too.
  assign period_hot = hot | (ovr_s2 & OVR_I_blank_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag       <= '0;
      sgn1      <= 1'b0;
      duty_calc <= '0;
      sgn2      <= 1'b0;
      ovr_s1    <= 1'b0;
      ovr_s2    <= 1'b0;
    end else begin
      mag       <= spd[11] ? (~spd + 12'd1) : spd;
      sgn1      <= spd[11];
      duty_calc <= calc_next;
      sgn2      <= sgn1;
      ovr_s1    <= OVR_I;
      ovr_s2    <= ovr_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      dir          <= 1'b1;
      dead_cnt     <= '0;
      ovr_cnt      <= '0;
      hot          <= 1'b0;
      duty         <= '0;
      fwd          <= 1'b1;
      rev          <= 1'b0;
      OVR_I_shtdwn <= 1'b0;
    end else begin
      if (state != FAULT) begin
        if (PWM_synch) begin
          hot <= 1'b0;
          if (!period_hot)           ovr_cnt <= '0;
          else if (ovr_cnt != OVR_MAX) ovr_cnt <= ovr_cnt + 1'b1;
        end else if (ovr_s2 && OVR_I_blank_n) begin
          hot <= 1'b1;
        end
      end

      if (state != FAULT && ovr_cnt == OVR_MAX) begin
        state        <= FAULT;
        duty         <= '0;
        fwd          <= 1'b0;
        rev          <= 1'b0;
        OVR_I_shtdwn <= 1'b1;
        hot          <= 1'b0;
      end else begin
        case (state)
          RUN: if (PWM_synch) begin
            if (duty_calc == '0) begin
              duty <= '0;
            end else if (sgn2 == ~dir) begin
              duty <= duty_calc;
              fwd  <= dir;
              rev  <= ~dir;
            end else begin
              duty     <= '0;
              fwd      <= 1'b0;
              rev      <= 1'b0;
              dead_cnt <= DEAD_INIT;
              state    <= DEAD;
            end
          end
          DEAD: if (PWM_synch) begin
            dead_cnt <= dead_cnt - 1'b1;
            // Direction is taken from whatever sign is present at exit.
            if (dead_cnt == DW'(1)) begin
              dir   <= ~sgn2;
              state <= RUN;
              if (duty_calc == '0) begin
                duty <= '0;
              end else begin
                duty <= duty_calc;
                fwd  <= ~sgn2;
                rev  <= sgn2;
              end
            end
          end
          FAULT: if (clr_fault) begin
            OVR_I_shtdwn <= 1'b0;
            ovr_cnt      <= '0;
            dead_cnt     <= DEAD_INIT;
            state        <= DEAD;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mtr_duty_ctrl.sv
// Bench for mtr_duty_ctrl: vector table, over-current/fault/reset sequences,
// and randomized speed commands against a period-level reference model.
module tb_mtr_duty_ctrl;

  localparam int ST_RUN = 0, ST_DEAD = 1, ST_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] spd = '0;
  logic        PWM_synch = 1'b0;
  logic        OVR_I_blank_n = 1'b1;
  logic        OVR_I = 1'b0;
  logic        clr_fault = 1'b0;
  logic [10:0] duty;
  logic        fwd;
  logic        rev;
  logic        OVR_I_shtdwn;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  mtr_duty_ctrl dut (
    .clk(clk), .rst_n(rst_n), .spd(spd), .PWM_synch(PWM_synch),
    .OVR_I_blank_n(OVR_I_blank_n), .OVR_I(OVR_I), .clr_fault(clr_fault),
    .duty(duty), .fwd(fwd), .rev(rev), .OVR_I_shtdwn(OVR_I_shtdwn),
    .state_dbg(state_dbg)
  );

  always #10 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int e_duty, input int e_fwd,
                         input int e_rev, input int e_st);
    chk({name, "_duty"}, int'(duty), e_duty);
    chk({name, "_fwd"}, int'(fwd), e_fwd);
    chk({name, "_rev"}, int'(rev), e_rev);
    chk({name, "_state"}, int'(state_dbg), e_st);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    PWM_synch = 1'b0;
    clr_fault = 1'b0;
    OVR_I = 1'b0;
    OVR_I_blank_n = 1'b1;
    repeat (2) tick;
    rst_n = 1'b1;
  endtask

  task automatic synch_pulse;
    PWM_synch = 1'b1;
    tick;
    PWM_synch = 1'b0;
  endtask

  task automatic set_and_synch(input int v);
    spd = 12'(v);
    repeat (3) tick;
    synch_pulse;
  endtask

  // 10-cycle PWM period, comparator high mid-period when hot, synch on last cycle.
  task automatic ovr_period(input bit hot);
    for (int i = 0; i < 10; i++) begin
      OVR_I = hot && (i >= 2) && (i <= 4);
      PWM_synch = (i == 9);
      tick;
    end
    PWM_synch = 1'b0;
    OVR_I = 1'b0;
  endtask

  function automatic int duty_of(input int s);
    int m;
    m = (s < 0) ? -s : s;
    if (m == 0) return 0;
    return (m + 160 > 2047) ? 2047 : m + 160;
  endfunction

  typedef struct {
    int spd;
    int duty;
    int fwd;
    int rev;
    int st;
  } vec_t;

  vec_t tbl[18];

  // Reference model: direction and duty decided once per PWM period.
  int  hist[$];
  int  m_state, m_dead, m_duty, m_fwd, m_rev;
  bit  m_dir;

  task automatic model_synch(input int s);
    int  d;
    bit  neg;
    d = duty_of(s);
    neg = (s < 0);
    if (m_state == ST_RUN) begin
      if (d == 0) m_duty = 0;
      else if (neg == !m_dir) begin
        m_duty = d; m_fwd = m_dir; m_rev = !m_dir;
      end else begin
        m_duty = 0; m_fwd = 0; m_rev = 0; m_dead = 2; m_state = ST_DEAD;
      end
    end else begin
      m_dead--;
      if (m_dead == 0) begin
        m_dir = !neg;
        m_state = ST_RUN;
        m_duty = d;
        if (d != 0) begin m_fwd = m_dir; m_rev = !m_dir; end
      end
    end
  endtask

  initial begin
    tbl[0]  = '{500,   660, 1, 0, ST_RUN};
    tbl[1]  = '{1,     161, 1, 0, ST_RUN};
    tbl[2]  = '{1886, 2046, 1, 0, ST_RUN};
    tbl[3]  = '{1887, 2047, 1, 0, ST_RUN};
    tbl[4]  = '{2000, 2047, 1, 0, ST_RUN};
    tbl[5]  = '{-2048,   0, 0, 0, ST_DEAD};
    tbl[6]  = '{-2048,   0, 0, 0, ST_DEAD};
    tbl[7]  = '{-2048,2047, 0, 1, ST_RUN};
    tbl[8]  = '{0,       0, 0, 1, ST_RUN};
    tbl[9]  = '{-5,    165, 0, 1, ST_RUN};
    tbl[10] = '{5,       0, 0, 0, ST_DEAD};
    tbl[11] = '{-7,      0, 0, 0, ST_DEAD};
    tbl[12] = '{0,       0, 0, 0, ST_RUN};
    tbl[13] = '{3,     163, 1, 0, ST_RUN};
    tbl[14] = '{0,       0, 1, 0, ST_RUN};
    tbl[15] = '{-1,      0, 0, 0, ST_DEAD};
    tbl[16] = '{-1,      0, 0, 0, ST_DEAD};
    tbl[17] = '{-1,    161, 0, 1, ST_RUN};

    do_reset;
    chk_out("reset", 0, 1, 0, ST_RUN);
    chk("reset_shtdwn", int'(OVR_I_shtdwn), 0);

    spd = 12'd500;
    repeat (6) tick;
    chk_out("pre_synch", 0, 1, 0, ST_RUN);

    for (int i = 0; i < 18; i++) begin
      set_and_synch(tbl[i].spd);
      chk_out($sformatf("tbl%0d", i), tbl[i].duty, tbl[i].fwd, tbl[i].rev, tbl[i].st);
    end

    // Over-current and fault recovery sequences.
    do_reset;
    set_and_synch(100);
    chk_out("fwd100", 260, 1, 0, ST_RUN);

    clr_fault = 1'b1;
    tick;
    clr_fault = 1'b0;
    chk_out("clr_in_run", 260, 1, 0, ST_RUN);
    chk("clr_in_run_shtdwn", int'(OVR_I_shtdwn), 0);

    OVR_I_blank_n = 1'b0;
    OVR_I = 1'b1;
    for (int p = 0; p < 10; p++) begin
      repeat (9) tick;
      synch_pulse;
    end
    OVR_I = 1'b0;
    repeat (3) tick;
    OVR_I_blank_n = 1'b1;
    chk_out("blanked", 260, 1, 0, ST_RUN);
    chk("blanked_shtdwn", int'(OVR_I_shtdwn), 0);

    for (int p = 0; p < 3; p++) ovr_period(1'b1);
    chk("hot3_shtdwn", int'(OVR_I_shtdwn), 0);
    ovr_period(1'b0);
    for (int p = 0; p < 3; p++) ovr_period(1'b1);
    chk("cool_reset_shtdwn", int'(OVR_I_shtdwn), 0);
    chk_out("cool_reset", 260, 1, 0, ST_RUN);
    ovr_period(1'b1);
    chk("hot4_synch_edge_shtdwn", int'(OVR_I_shtdwn), 0);
    tick;
    chk("fault_entry_shtdwn", int'(OVR_I_shtdwn), 1);
    chk_out("fault_entry", 0, 0, 0, ST_FAULT);

    ovr_period(1'b1);
    ovr_period(1'b0);
    chk_out("fault_hold", 0, 0, 0, ST_FAULT);

    clr_fault = 1'b1;
    tick;
    clr_fault = 1'b0;
    chk("clr_shtdwn", int'(OVR_I_shtdwn), 0);
    chk_out("clr", 0, 0, 0, ST_DEAD);
    ovr_period(1'b0);
    chk_out("clr_synch1", 0, 0, 0, ST_DEAD);
    ovr_period(1'b0);
    chk_out("clr_synch2", 260, 1, 0, ST_RUN);

    // Asynchronous reset mid-dead-time.
    set_and_synch(-100);
    chk_out("enter_dead", 0, 0, 0, ST_DEAD);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 1, 0, ST_RUN);
    spd = 12'd100;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick;
    synch_pulse;
    chk_out("post_rst", 260, 1, 0, ST_RUN);

    // Randomized speed commands against the reference model.
    do_reset;
    hist = {0, 0};
    m_state = ST_RUN; m_dead = 0; m_duty = 0; m_fwd = 1; m_rev = 0; m_dir = 1'b1;
    begin
      int gap;
      int v;
      gap = $urandom_range(3, 12);
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 2))
            0: v = 0;
            1: v = int'($signed(12'($urandom_range(0, 4095))));
            default: v = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 50) : -$urandom_range(1, 50);
          endcase
          spd = 12'(v);
        end
        gap--;
        PWM_synch = (gap == 0);
        hist.push_back(int'($signed(spd)));
        if (hist.size() > 4) void'(hist.pop_front());
        if (PWM_synch) begin
          model_synch(hist[hist.size() - 3]);
          gap = $urandom_range(3, 12);
        end
        tick;
        chk("rnd_duty", int'(duty), m_duty);
        chk("rnd_fwd", int'(fwd), m_fwd);
        chk("rnd_rev", int'(rev), m_rev);
      end
      PWM_synch = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
